serial_fullsub: RTL
===================

Name: serial_fullsub

Overview:
- Bit-serial N-bit subtractor; the inverse datapath of the team's ripple-carry full-adder chain.
- Computes diff = a - b - borrow_in, one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop.
- Start/busy/done handshake.
- Used where area matters more than latency, and as a sequential cross-check against the combinational adder chain (a = sum, b = addend recovers the other operand).

Parameters:
N  3  operand/result width in bits; legal range N >= 1

Ports:
clk         input   1  rising-edge clock
rst_n       input   1  asynchronous active-low reset
start       input   1  request; sampled only in IDLE
a           input   N  minuend; captured on accepted start
b           input   N  subtrahend; captured on accepted start
borrow_in   input   1  borrow into bit 0; captured on accepted start
busy        output  1  high while RUN
done        output  1  one-cycle pulse, result valid
diff        output  N  registered difference; held between operations
borrow_out  output  1  borrow out of bit N-1; held with diff

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low. While rst_n = 0:
  - state = IDLE
  - busy = 0, done = 0
  - diff = 0, borrow_out = 0
  - internal shift registers, borrow FF and bit counter = 0
- States: IDLE, RUN, DONE.
- IDLE:
  - start = 1 at a rising edge -> capture a, b, borrow_in into shift regs and borrow FF; counter = 0; go to RUN.
  - start = 0 -> remain in IDLE.
- RUN (busy = 1), one bit per edge, with x = a_sr[0], y = b_sr[0], br = borrow FF:
  - d = x ^ y ^ br
  - br_next = (~x & y) | (~(x ^ y) & br)
  - d shifts into the result register at the MSB end; a_sr and b_sr shift right; counter increments.
  - After the edge processing bit N-1 (counter == N-1): go to DONE; load diff from the result register including that final d; load borrow_out = br_next.
- DONE:
  - Lasts exactly one cycle: done = 1, busy = 0.
  - Then go to IDLE unconditionally.
- Latency: start sampled at edge k -> busy high for cycles k+1 .. k+N -> done high in cycle k+N+1. Next start accepted at edge k+N+2 at the earliest. Throughput is one result per N+2 cycles.
- start while RUN or DONE: ignored, no queuing. A and b changes after capture have no effect.
- diff and borrow_out: change only on the transition into DONE or on reset; stable during RUN (previous result visible).
- Arithmetic: modulo 2^N.
  - borrow_out = 1 iff a < b + borrow_in as unsigned integers.
  - {borrow_out, diff} equals the (N+1)-bit two's-complement of a - b - borrow_in.
- N = 1: RUN lasts one cycle; the counter must not underflow or overflow. Counter width = max(1, clog2(N)).
- Reset asserted mid-RUN or during DONE: immediate return to IDLE. The done pulse is not produced; the previous diff is cleared to 0.
- Reset deassertion takes effect synchronously at the next clk edge; start on that first edge is accepted.

Test Plan:
- N=3, a=5, b=3, borrow_in=0, start one cycle -> busy for 3 cycles, then done pulse 1 cycle; diff=2, borrow_out=0; diff stays 2 after done.
- N=3, a=3, b=5, borrow_in=0 -> diff=6 (3'b110), borrow_out=1.
- N=3, a=0, b=0, borrow_in=1 -> diff=7, borrow_out=1. Follow with a=7, b=7, borrow_in=0 -> diff=0, borrow_out=0.
- Handshake: start held high continuously with a=6, b=1, then a changed to 0 mid-RUN -> exactly one capture per N+2 cycles.
  - First result diff=5, borrow_out=0.
  - done pulses are spaced 5 cycles apart.
  - No done is ever concurrent with busy.
- Reset mid-operation: start a=4, b=1, assert rst_n=0 in second RUN cycle -> busy=0, done=0, diff=0 immediately (asynchronously). After release, start a=2, b=1 -> diff=1, borrow_out=0.
- Exhaustive sweep for N=3 and N=1: all a, b, borrow_in -> {borrow_out, diff} matches (a - b - borrow_in) mod 2^(N+1). For N=1, done follows start by 2 cycles.

Source files
------------

// File: rtl/serial_fullsub.sv
// Bit-serial N-bit subtractor: diff = a - b - borrow_in, one bit per clock, LSB first.
// One full-subtractor cell plus a borrow flop; start/busy/done handshake.
//
//   state  | meaning
//   IDLE   | waiting for start; operands captured on the accepting edge
//   RUN    | one difference bit per clock, busy = 1
//   DONE   | single-cycle done pulse, diff/borrow_out freshly loaded
module serial_fullsub #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         borrow_in,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         borrow_out
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   a_sr_q, a_sr_d;
    logic [N-1:0]   b_sr_q, b_sr_d;
    logic [N-1:0]   res_q, res_d;
    logic           br_q, br_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   diff_q, diff_d;
    logic           bout_q, bout_d;

    logic           x_bit;
    logic           y_bit;
    logic           d_bit;
    logic           br_nxt;
    logic           last_bit;
    logic [N-1:0]   res_shift;

    assign x_bit    = a_sr_q[0];
    assign y_bit    = b_sr_q[0];
    assign d_bit    = x_bit ^ y_bit ^ br_q;
    assign br_nxt   = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & br_q);
    assign last_bit = (cnt_q == CW'(N - 1));

    // New bit enters at the MSB so that after N shifts bit 0 sits at the LSB.
    always_comb begin
        res_shift        = res_q >> 1;
        res_shift[N-1]   = d_bit;
    end

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        res_d   = res_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    br_d    = borrow_in;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                br_d   = br_nxt;
                res_d  = res_shift;
                if (last_bit) begin
                    diff_d  = res_shift;
                    bout_d  = br_nxt;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    assign busy       = (state_q == S_RUN);
    assign done       = (state_q == S_DONE);
    assign diff       = diff_q;
    assign borrow_out = bout_q;

endmodule
